// File: rtl/biu_constants_pkg.sv
// Bus interface constants shared by the load/store path and its memory targets.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

endpackage

// File: rtl/riscv_pma_pkg.sv
// Types and defaults for PMA-based routing of memory requests.
package riscv_pma_pkg;

    localparam int EXT_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DC  = 2'd1,
        WAIT_EXT = 2'd2,
        WAIT_TCM = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/riscv_timeout_cnt.sv
// Cycle counter that flags when an enabled wait has lasted TIMEOUT cycles.
module riscv_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of completed wait cycles, so the last allowed cycle sees TIMEOUT-1
    assign expired = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/riscv_mem_dispatch.sv
// Routes one upstream memory request at a time to the data cache, external bus or TCM
// and returns a single completion pulse (or an immediate fault/misaligned pulse).
module riscv_mem_dispatch
    import biu_constants_pkg::*;
    import riscv_pma_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PLEN        = (XLEN == 32) ? 34 : 56,
    parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req_i,
    input  logic [PLEN-1:0]  adr_i,
    input  biu_size_t        size_i,
    input  logic             we_i,
    input  logic             lock_i,
    input  logic [XLEN-1:0]  d_i,
    input  logic             kill_i,
    output logic             ready_o,

    input  logic             exception_i,
    input  logic             misaligned_i,
    input  logic             is_cache_access_i,
    input  logic             is_ext_access_i,
    input  logic             is_tcm_access_i,

    output logic             ack_o,
    output logic [XLEN-1:0]  q_o,
    output logic             err_o,
    output logic             access_fault_o,
    output logic             misaligned_o,

    output logic             dc_req_o,
    output logic [PLEN-1:0]  dc_adr_o,
    output biu_size_t        dc_size_o,
    output logic             dc_we_o,
    output logic [XLEN-1:0]  dc_d_o,
    input  logic             dc_ack_i,
    input  logic             dc_err_i,
    input  logic [XLEN-1:0]  dc_q_i,

    output logic             ext_req_o,
    output logic [PLEN-1:0]  ext_adr_o,
    output biu_size_t        ext_size_o,
    output logic             ext_we_o,
    output logic             ext_lock_o,
    output logic [XLEN-1:0]  ext_d_o,
    input  logic             ext_ack_i,
    input  logic             ext_err_i,
    input  logic [XLEN-1:0]  ext_q_i,

    output logic             tcm_req_o,
    output logic [PLEN-1:0]  tcm_adr_o,
    output biu_size_t        tcm_size_o,
    output logic             tcm_we_o,
    output logic [XLEN-1:0]  tcm_d_o,
    input  logic             tcm_ack_i,
    input  logic             tcm_err_i,
    input  logic [XLEN-1:0]  tcm_q_i
);

    dispatch_state_t state;
    logic            kill_r;
    logic [PLEN-1:0] adr_r;
    biu_size_t       size_r;
    logic            we_r;
    logic            lock_r;
    logic [XLEN-1:0] d_r;

    logic accept;
    logic fault;
    logic go_ext;
    logic ext_expired;
    logic squash;

    function automatic logic [XLEN-1:0] resp_q(input logic we, input logic [XLEN-1:0] q);
        return we ? '0 : q;
    endfunction

    assign ready_o = (state == IDLE);
    assign accept  = req_i && ready_o;
    // An access that no PMA region claims is reported exactly like a PMA exception.
    assign fault   = exception_i || !(is_cache_access_i || is_ext_access_i || is_tcm_access_i);
    assign go_ext  = accept && !fault && !misaligned_i && !is_tcm_access_i
                     && !is_cache_access_i && is_ext_access_i;
    assign squash  = kill_r || kill_i;

    riscv_timeout_cnt #(
        .TIMEOUT (EXT_TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (go_ext),
        .en      (state == WAIT_EXT),
        .expired (ext_expired)
    );

    always_ff @(posedge clk_i) begin
        if (accept) begin
            adr_r  <= adr_i;
            size_r <= size_i;
            we_r   <= we_i;
            lock_r <= lock_i;
            d_r    <= d_i;
        end
    end

    assign dc_adr_o   = adr_r;
    assign dc_size_o  = size_r;
    assign dc_we_o    = we_r;
    assign dc_d_o     = d_r;
    assign ext_adr_o  = adr_r;
    assign ext_size_o = size_r;
    assign ext_we_o   = we_r;
    assign ext_lock_o = lock_r;
    assign ext_d_o    = d_r;
    assign tcm_adr_o  = adr_r;
    assign tcm_size_o = size_r;
    assign tcm_we_o   = we_r;
    assign tcm_d_o    = d_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            dc_req_o       <= 1'b0;
            ext_req_o      <= 1'b0;
            tcm_req_o      <= 1'b0;
            ack_o          <= 1'b0;
            err_o          <= 1'b0;
            access_fault_o <= 1'b0;
            misaligned_o   <= 1'b0;
            q_o            <= '0;
            kill_r         <= 1'b0;
        end else begin
            ack_o          <= 1'b0;
            err_o          <= 1'b0;
            access_fault_o <= 1'b0;
            misaligned_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (fault) begin
                            access_fault_o <= !kill_i;
                            ack_o          <= !kill_i;
                        end else if (misaligned_i) begin
                            misaligned_o <= !kill_i;
                            ack_o        <= !kill_i;
                        end else if (is_tcm_access_i) begin
                            state     <= WAIT_TCM;
                            tcm_req_o <= 1'b1;
                            kill_r    <= kill_i;
                        end else if (is_cache_access_i) begin
                            state    <= WAIT_DC;
                            dc_req_o <= 1'b1;
                            kill_r   <= kill_i;
                        end else begin
                            state     <= WAIT_EXT;
                            ext_req_o <= 1'b1;
                            kill_r    <= kill_i;
                        end
                    end
                end
                WAIT_DC: begin
                    if (dc_ack_i || dc_err_i) begin
                        state    <= IDLE;
                        dc_req_o <= 1'b0;
                        kill_r   <= 1'b0;
                        if (!squash) begin
                            ack_o <= 1'b1;
                            err_o <= dc_err_i;
                            q_o   <= resp_q(we_r, dc_q_i);
                        end
                    end else if (kill_i) begin
                        kill_r <= 1'b1;
                    end
                end
                WAIT_TCM: begin
                    if (tcm_ack_i || tcm_err_i) begin
                        state     <= IDLE;
                        tcm_req_o <= 1'b0;
                        kill_r    <= 1'b0;
                        if (!squash) begin
                            ack_o <= 1'b1;
                            err_o <= tcm_err_i;
                            q_o   <= resp_q(we_r, tcm_q_i);
                        end
                    end else if (kill_i) begin
                        kill_r <= 1'b1;
                    end
                end
                WAIT_EXT: begin
                    // A response in the final allowed cycle wins over the timeout.
                    if (ext_ack_i || ext_err_i) begin
                        state     <= IDLE;
                        ext_req_o <= 1'b0;
                        kill_r    <= 1'b0;
                        if (!squash) begin
                            ack_o <= 1'b1;
                            err_o <= ext_err_i;
                            q_o   <= resp_q(we_r, ext_q_i);
                        end
                    end else if (ext_expired) begin
                        state     <= IDLE;
                        ext_req_o <= 1'b0;
                        kill_r    <= 1'b0;
                        ack_o     <= !squash;
                        err_o     <= !squash;
                    end else if (kill_i) begin
                        kill_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_mem_dispatch.md
RISCV_MEM_DISPATCH -- requirements
Module: riscv_mem_dispatch

Interface
REQ-001 Parameters SHALL be: XLEN, 32, data width; PLEN, 34 when XLEN==32 else 56, physical address width; EXT_TIMEOUT, 255, max cycles waiting for ext_ack_i.
REQ-002 Clock/reset SHALL be: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-003 Upstream ports SHALL be: req_i in 1 request; adr_i in PLEN address; size_i in biu_size_t transfer size; we_i in 1 write; lock_i in 1 AMO; d_i in XLEN write data; kill_i in 1 discard pending response; ready_o out 1 can accept.
REQ-004 PMA-result inputs, all 1 bit, SHALL be: exception_i, misaligned_i, is_cache_access_i, is_ext_access_i, is_tcm_access_i (same cycle as req_i).
REQ-005 Response ports SHALL be: ack_o out 1 completion pulse; q_o out XLEN read data; err_o out 1 bus error/timeout; access_fault_o out 1; misaligned_o out 1.
REQ-006 Per target T in {dc, ext, tcm}, ports SHALL be: T_req_o out 1; T_adr_o out PLEN; T_size_o out biu_size_t; T_we_o out 1; T_lock_o out 1 (ext only); T_d_o out XLEN; T_ack_i in 1; T_err_i in 1; T_q_i in XLEN.

Function
REQ-007 FSM states SHALL be IDLE, WAIT_DC, WAIT_EXT, WAIT_TCM; ready_o = (state==IDLE), combinational from state only.
REQ-008 Accept SHALL occur when req_i & ready_o; adr/size/we/lock/d are registered at accept.
REQ-009 On accept with exception_i=1, FSM SHALL stay IDLE and pulse access_fault_o and ack_o for one cycle in the next cycle (N+1).
REQ-010 On accept with exception_i=0 and misaligned_i=1, FSM SHALL stay IDLE and pulse misaligned_o and ack_o at N+1.
REQ-011 Otherwise target SHALL be chosen with priority tcm > cache > ext; if no is_*_access_i is set, the access SHALL be treated as exception_i=1.
REQ-012 Selected T_req_o SHALL assert at N+1 from a register and hold, with stable address/data, until the cycle T_ack_i or T_err_i is sampled high.
REQ-013 At most one T_req_o SHALL be high in any cycle.
REQ-014 On T_ack_i/T_err_i, FSM SHALL return to IDLE; next cycle ack_o=1, q_o=registered T_q_i (0 for writes), err_o=T_err_i.
REQ-015 Minimum accept-to-ack_o latency for a target acking in its first request cycle SHALL be 2 cycles.
REQ-016 In WAIT_EXT, an 8-bit-minimum counter SHALL count cycles and clear at entry; reaching EXT_TIMEOUT without ack SHALL drop ext_req_o, return to IDLE, and pulse ack_o+err_o.
REQ-017 kill_i high at any point while not IDLE SHALL set a sticky flag; the target transaction still completes, but ack_o/err_o/q_o SHALL be suppressed and the flag cleared on return to IDLE.
REQ-018 kill_i in the same cycle as an accept SHALL suppress that request's fault/misaligned/ack pulse.
REQ-019 When not pulsing, ack_o, err_o, access_fault_o and misaligned_o SHALL be 0; q_o holds its last value.
REQ-020 A new request SHALL be acceptable in the same cycle ack_o is high, which is back-to-back throughput.

Reset
REQ-021 rst_i sampled high SHALL force, at the next edge, state=IDLE, all T_req_o=0, ack_o=err_o=access_fault_o=misaligned_o=0, q_o=0, kill flag=0, counter=0.
REQ-022 Reset during WAIT_* SHALL abandon the transaction without any ack_o; a target ack arriving later SHALL be ignored.

Structure
REQ-023 The state enum and the EXT_TIMEOUT default SHALL live in riscv_pma_pkg; biu_size_t comes from biu_constants_pkg.
REQ-024 The timeout counter SHALL be a sub-module riscv_timeout_cnt, with inputs clk_i, rst_i, clr, en and output expired.

Verification
REQ-025 Read, is_tcm=1, tcm_ack_i in first cycle, tcm_q_i=0xDEADBEEF -> tcm_req_o at N+1, ack_o at N+2, q_o=0xDEADBEEF, err_o=0.
REQ-026 req_i with exception_i=1 -> no T_req_o; access_fault_o=ack_o=1 at N+1; ready_o stays 1.
REQ-027 Ext write, no ack, EXT_TIMEOUT=4 -> ext_req_o high exactly 4 cycles, then ack_o=err_o=1 once.
REQ-028 Cache read with kill_i pulsed in WAIT_DC, dc_ack_i 3 cycles later -> dc_req_o drops, no ack_o, ready_o=1 the following cycle.
REQ-029 rst_i asserted during WAIT_EXT, then ext_ack_i -> ext_req_o=0 next edge, no ack_o ever.
REQ-030 is_tcm=is_cache=1 -> only tcm_req_o asserts; then back-to-back accepts on ack_o cycles complete in order.
